// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational-read instruction ROM between the
// fetch port (if_*) and a load-side literal read port (ls_*).
// Ports: clk/rst_n; if_req/if_addr/if_flush -> if_gnt, if_rvalid/if_rdata/if_err;
//        ls_req/ls_addr -> ls_gnt, ls_rvalid/ls_rdata/ls_err; mem_addr/mem_en -> ROM, mem_rdata <- ROM.
// Grants are combinational; each response returns exactly one cycle after its grant.
// Fetch has priority unless the load side has been denied STARVE_MAX cycles in a row.
module imem_arbiter #(
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_DATA = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [WIDTH_ADDR-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WIDTH_DATA-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  ls_req,
  input  logic [WIDTH_ADDR-1:0] ls_addr,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [WIDTH_DATA-1:0] ls_rdata,
  output logic                  ls_err,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [WIDTH_DATA-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]            starve_cnt;
  logic [WIDTH_ADDR-1:0] mem_addr_q;
  logic                  if_vld_q, if_err_q, ls_vld_q, ls_err_q;
  logic [WIDTH_DATA-1:0] if_rdata_q, ls_rdata_q;
  logic                  ls_wins;
  logic                  misaligned;
  logic [WIDTH_DATA-1:0] rdata_in;

  always_comb begin
    // Load side wins when fetch is absent or flushed, or when it has starved.
    ls_wins    = ls_req & (if_flush | ~if_req | (starve_cnt == STARVE_LIM));
    // rst_n gates the grants so nothing is granted while reset is held.
    ls_gnt     = rst_n & ls_wins;
    if_gnt     = rst_n & if_req & ~if_flush & ~ls_wins;
    mem_en     = if_gnt | ls_gnt;
    mem_addr   = mem_addr_q;
    if (ls_gnt)
      mem_addr = ls_addr;
    else if (if_gnt)
      mem_addr = if_addr;
    misaligned = |mem_addr[1:0];
    rdata_in   = misaligned ? '0 : mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      mem_addr_q <= '0;
      if_vld_q   <= 1'b0;
      if_err_q   <= 1'b0;
      ls_vld_q   <= 1'b0;
      ls_err_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (ls_req && !ls_gnt)
        starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;

      if (mem_en)
        mem_addr_q <= mem_addr;

      if_vld_q <= if_gnt;
      if_err_q <= if_gnt & misaligned;
      ls_vld_q <= ls_gnt;
      ls_err_q <= ls_gnt & misaligned;
      if (if_gnt)
        if_rdata_q <= rdata_in;
      if (ls_gnt)
        ls_rdata_q <= rdata_in;
    end
  end

  // A flush in the response cycle kills the fetch response; ls is unaffected.
  assign if_rvalid = if_vld_q & ~if_flush;
  assign if_err    = if_err_q & ~if_flush;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_vld_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: table-driven check of imem_arbiter against a small ROM,
// plus hand-written sequences for starvation, request withdrawal and reset.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_en;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_rdata;

  logic [31:0] rom [0:31];
  assign mem_rdata = rom[mem_addr[6:2]];

  int total = 0;
  int bad   = 0;

  imem_arbiter #(.WIDTH_ADDR(32), .WIDTH_DATA(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic ifr; logic [31:0] ifa; logic ifl; logic lsr; logic [31:0] lsa;
    logic ig; logic lg; logic me; logic [31:0] ma;
    logic iv; logic [31:0] id; logic ie;
    logic lv; logic [31:0] ld; logic le;
  } vec_t;

  vec_t vecs [13];

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hC0DE_0000 + i;
    rom[4] = 32'h0050_0093;

    //          ifr  ifa     ifl lsr  lsa     ig lg me  ma      iv  id            ie  lv  ld            le
    vecs[0]  = '{0, 32'h00, 0, 0, 32'h00,  0, 0, 0, 32'h00,  0, 32'h0,         0,  0, 32'h0,         0}; // idle
    vecs[1]  = '{1, 32'h10, 0, 0, 32'h00,  1, 0, 1, 32'h10,  0, 32'h0,         0,  0, 32'h0,         0}; // single fetch
    vecs[2]  = '{0, 32'h00, 0, 0, 32'h00,  0, 0, 0, 32'h10,  1, 32'h00500093,  0,  0, 32'h0,         0};
    vecs[3]  = '{0, 32'h00, 0, 1, 32'h06,  0, 1, 1, 32'h06,  0, 32'h00500093,  0,  0, 32'h0,         0}; // misaligned ls
    vecs[4]  = '{0, 32'h00, 0, 0, 32'h00,  0, 0, 0, 32'h06,  0, 32'h00500093,  0,  1, 32'h0,         1};
    vecs[5]  = '{0, 32'h00, 0, 1, 32'h00,  0, 1, 1, 32'h00,  0, 32'h00500093,  0,  0, 32'h0,         0}; // back-to-back
    vecs[6]  = '{1, 32'h04, 0, 0, 32'h00,  1, 0, 1, 32'h04,  0, 32'h00500093,  0,  1, 32'hC0DE0000,  0};
    vecs[7]  = '{0, 32'h00, 0, 1, 32'h08,  0, 1, 1, 32'h08,  1, 32'hC0DE0001,  0,  0, 32'hC0DE0000,  0};
    vecs[8]  = '{0, 32'h00, 0, 0, 32'h00,  0, 0, 0, 32'h08,  0, 32'hC0DE0001,  0,  1, 32'hC0DE0002,  0};
    vecs[9]  = '{1, 32'h20, 0, 0, 32'h00,  1, 0, 1, 32'h20,  0, 32'hC0DE0001,  0,  0, 32'hC0DE0002,  0}; // flush
    vecs[10] = '{1, 32'h24, 1, 1, 32'h40,  0, 1, 1, 32'h40,  0, 32'hC0DE0008,  0,  0, 32'hC0DE0002,  0};
    vecs[11] = '{0, 32'h00, 1, 0, 32'h00,  0, 0, 0, 32'h40,  0, 32'hC0DE0008,  0,  1, 32'hC0DE0010,  0};
    vecs[12] = '{0, 32'h00, 0, 0, 32'h00,  0, 0, 0, 32'h40,  0, 32'hC0DE0008,  0,  0, 32'hC0DE0010,  0};

    // Reset state, with a request pending to show that no grant leaks out.
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10; if_flush = 1'b0; ls_req = 1'b1; ls_addr = 32'h4;
    #2;
    chk("rst if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst ls_gnt", {31'b0, ls_gnt}, 32'd0);
    chk("rst mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst ls_rdata", ls_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst hold ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if_req = vecs[i].ifr; if_addr = vecs[i].ifa; if_flush = vecs[i].ifl;
      ls_req = vecs[i].lsr; ls_addr = vecs[i].lsa;
      #2;
      chk($sformatf("v%0d if_gnt", i),    {31'b0, if_gnt},    {31'b0, vecs[i].ig});
      chk($sformatf("v%0d ls_gnt", i),    {31'b0, ls_gnt},    {31'b0, vecs[i].lg});
      chk($sformatf("v%0d mem_en", i),    {31'b0, mem_en},    {31'b0, vecs[i].me});
      chk($sformatf("v%0d mem_addr", i),  mem_addr,           vecs[i].ma);
      chk($sformatf("v%0d if_rvalid", i), {31'b0, if_rvalid}, {31'b0, vecs[i].iv});
      chk($sformatf("v%0d if_rdata", i),  if_rdata,           vecs[i].id);
      chk($sformatf("v%0d if_err", i),    {31'b0, if_err},    {31'b0, vecs[i].ie});
      chk($sformatf("v%0d ls_rvalid", i), {31'b0, ls_rvalid}, {31'b0, vecs[i].lv});
      chk($sformatf("v%0d ls_rdata", i),  ls_rdata,           vecs[i].ld);
      chk($sformatf("v%0d ls_err", i),    {31'b0, ls_err},    {31'b0, vecs[i].le});
    end

    // Starvation: both held -> IIIIL IIIIL.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0; if_flush = 1'b0; ls_req = 1'b1; ls_addr = 32'h4;
    for (int k = 0; k < 10; k++) begin
      #2;
      chk($sformatf("starve%0d if_gnt", k), {31'b0, if_gnt}, (k % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve%0d ls_gnt", k), {31'b0, ls_gnt}, (k % 5 == 4) ? 32'd1 : 32'd0);
      if (k % 5 == 0 && k > 0)
        chk($sformatf("starve%0d cnt", k), {28'b0, dut.starve_cnt}, 32'd0);
      @(negedge clk);
    end

    // Withdrawal: dropping ls_req clears the count, so 4 more fetch grants precede ls.
    for (int j = 0; j < 9; j++) begin
      ls_req = (j != 3);
      #2;
      chk($sformatf("wd%0d if_gnt", j), {31'b0, if_gnt}, (j == 8) ? 32'd0 : 32'd1);
      chk($sformatf("wd%0d ls_gnt", j), {31'b0, ls_gnt}, (j == 8) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    ls_req = 1'b0; if_req = 1'b0;

    // Reset mid-operation: pending fetch response is discarded.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #2;
    chk("rm grant", {31'b0, if_gnt}, 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rm if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rm if_rdata", if_rdata, 32'h0);
    chk("rm mem_addr", mem_addr, 32'h0);
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    chk("rm no gnt", {31'b0, if_gnt}, 32'd0);
    @(negedge clk);
    chk("rm edge no gnt", {31'b0, if_gnt}, 32'd0);
    chk("rm edge if_rvalid", {31'b0, if_rvalid}, 32'd0);
    rst_n = 1'b1;
    #2;
    chk("rm resume gnt", {31'b0, if_gnt}, 32'd1);
    chk("rm resume addr", mem_addr, 32'h0);
    @(negedge clk);
    if_req = 1'b0;
    #2;
    chk("rm resp vld", {31'b0, if_rvalid}, 32'd1);
    chk("rm resp data", if_rdata, 32'hC0DE0000);
    chk("rm resp err", {31'b0, if_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_ADDR, default 32, byte address width.
REQ-002 SHALL have parameter WIDTH_DATA, default 32, instruction word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, number of consecutive denied load-side cycles that forces a load-side grant; legal range 1..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port if_req, input, 1, fetch-side read request.
REQ-007 SHALL have port if_addr, input, WIDTH_ADDR, fetch byte address.
REQ-008 SHALL have port if_flush, input, 1, kills the fetch grant in the current cycle and any fetch response still pending.
REQ-009 SHALL have port if_gnt, output, 1, fetch request accepted this cycle.
REQ-010 SHALL have ports if_rvalid (output, 1), if_rdata (output, WIDTH_DATA) and if_err (output, 1), carrying the fetch response.
REQ-011 SHALL have ports ls_req (input, 1), ls_addr (input, WIDTH_ADDR), ls_gnt (output, 1), ls_rvalid (output, 1), ls_rdata (output, WIDTH_DATA) and ls_err (output, 1), forming the load-side read port for literal/constant reads from instruction memory.
REQ-012 SHALL have port mem_addr, output, WIDTH_ADDR, byte address driven to the combinational-read instruction ROM.
REQ-013 SHALL have port mem_en, output, 1, high when mem_addr carries a granted access.
REQ-014 SHALL have port mem_rdata, input, WIDTH_DATA, ROM word returned combinationally for mem_addr.

Function
REQ-015 SHALL grant at most one requester per cycle; if_gnt and ls_gnt are never high together.
REQ-016 SHALL compute grants combinationally from the current req/flush inputs and the registered starvation state.
REQ-017 SHALL give fetch priority when both requesters are active, unless the starvation counter equals STARVE_MAX, in which case ls wins.
REQ-018 SHALL increment the starvation counter by 1 each cycle in which ls_req=1 and ls_gnt=0, saturating at STARVE_MAX.
REQ-019 SHALL clear the starvation counter to 0 on any cycle with ls_gnt=1 or ls_req=0.
REQ-020 SHALL force if_gnt=0 while if_flush=1; in that cycle ls is granted if ls_req=1.
REQ-021 SHALL drive mem_addr with the granted requester's address and mem_en=1 in the grant cycle; with no grant, mem_en=0 and mem_addr holds its last granted value.
REQ-022 SHALL register mem_rdata into the granted side's rdata register at the grant edge, and SHALL pulse that side's rvalid for exactly one cycle; read latency is 1 cycle.
REQ-023 SHALL hold each rdata register stable until that side's next response.
REQ-024 SHALL flag a misaligned access (address bits [1:0] non-zero) by returning rvalid=1 with err=1 one cycle later and rdata=0; the access is still granted and the grant is still counted.
REQ-025 SHALL suppress if_rvalid and if_err in a cycle where if_flush=1 and a fetch response is due; ls responses are never affected by if_flush.
REQ-026 SHALL accept back-to-back grants to the same or alternating sides every cycle, with no bubble.
REQ-027 SHALL require each requester to hold req and addr stable until its gnt; dropping req before gnt is legal and withdraws the request.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously drive if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err and mem_en to 0, and if_rdata, ls_rdata and mem_addr to 0.
REQ-029 SHALL clear the starvation counter and both pending-response flags on reset; a response pending when reset asserts is discarded.
REQ-030 SHALL issue no grant on the first rising edge at which rst_n is sampled 0, and SHALL resume arbitration on the first edge with rst_n=1.

Verification
REQ-031 Single fetch: if_req=1, if_addr=0x10, ROM[4]=0x00500093 -> if_gnt=1 and mem_addr=0x10 that cycle; next cycle if_rvalid=1, if_rdata=0x00500093, if_err=0.
REQ-032 Starvation: if_req and ls_req held at 1, STARVE_MAX=4 -> 4 fetch grants, then 1 ls grant, then the pattern repeats; the counter reads 0 after the ls grant.
REQ-033 Flush: fetch granted at addr 0x20, then if_flush=1 in the next cycle -> if_rvalid stays 0; a simultaneous ls_req at 0x40 is granted and ls_rvalid=1 the following cycle.
REQ-034 Misaligned: ls_addr=0x06 -> ls_gnt=1; next cycle ls_rvalid=1, ls_err=1, ls_rdata=0.
REQ-035 Reset mid-operation: rst_n dropped in the cycle after a fetch grant -> if_rvalid=0 immediately; after release with if_req=1 and addr 0x0, a normal grant occurs and ROM[0] is returned one cycle later.
REQ-036 Back-to-back: alternating ls/if requests at addresses 0x0, 0x4, 0x8 with no gaps -> one grant per cycle, each response exactly 1 cycle after its grant, rdata matches ROM[0], ROM[1], ROM[2].
